// File: rtl/mem_write_tracer_if.sv
// Data-memory write bus snooped by mem_write_tracer.
// Handshake: write_enable is a per-cycle strobe. Every rising clk edge that
// sees write_enable=1 is exactly one store of {address_to_mem, data_to_mem}.
// There is no ready/back-pressure path: the observer accepts every store.
interface mem_write_tracer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              write_enable;
   logic [ADDR_W-1:0] address_to_mem;
   logic [DATA_W-1:0] data_to_mem;

   // CPU side drives the bus
   modport master (output write_enable, address_to_mem, data_to_mem);
   // Tracer side only observes it
   modport slave  (input  write_enable, address_to_mem, data_to_mem);
endinterface

// File: rtl/mem_write_tracer.sv
// Run monitor for the single-cycle CPU: traces committed stores into a
// circular buffer, counts RUN cycles and ends the run on a store to
// HALT_ADDR (HALTED) or on reaching MAX_CYCLES (TIMEOUT).
// Optional feature: define TRACE_FILTER_EN to add filt_lo/filt_hi inputs that
// restrict which store addresses are traced (halt detection is unaffected).
module mem_write_tracer #(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                DEPTH      = 16,
   parameter int                CNT_W      = 16,
   parameter int                MAX_CYCLES = 250,
   parameter logic [ADDR_W-1:0] HALT_ADDR  = ADDR_W'(32'hFC),
   parameter logic [DATA_W-1:0] PASS_VALUE = DATA_W'(32'h1),
   localparam int               IDX_W      = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   mem_write_tracer_if.slave  mem_bus,
   input  logic [IDX_W-1:0]   rd_idx,
   output logic [ADDR_W-1:0]  rd_addr,
   output logic [DATA_W-1:0]  rd_data,
   output logic               rd_valid,
   output logic [IDX_W:0]     trace_count,
   output logic               overflow,
   output logic [CNT_W-1:0]   cycle_count,
   output logic               done,
   output logic               pass,
   output logic               timed_out,
   output logic [DATA_W-1:0]  halt_data,
`ifdef TRACE_FILTER_EN
   input  logic [ADDR_W-1:0]  filt_lo,
   input  logic [ADDR_W-1:0]  filt_hi,
`endif
   output logic [1:0]         state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_HALTED  = 2'd2,
      S_TIMEOUT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(MAX_CYCLES - 1);
   localparam logic [IDX_W:0]   FULL_CNT = (IDX_W + 1)'(DEPTH);

   state_t            state;
   logic [IDX_W-1:0]  wr_ptr;
   logic [ADDR_W-1:0] buf_addr [DEPTH];
   logic [DATA_W-1:0] buf_data [DEPTH];

   logic in_run;
   logic in_window;
   logic halt_hit;
   logic limit_hit;
   logic capture;
   logic full;
   logic [IDX_W-1:0] oldest;
   logic [IDX_W-1:0] phys_idx;

`ifdef TRACE_FILTER_EN
   assign in_window = (mem_bus.address_to_mem >= filt_lo) &&
                      (mem_bus.address_to_mem <= filt_hi);
`else
   assign in_window = 1'b1;
`endif

   assign in_run    = (state == S_RUN);
   assign halt_hit  = in_run && mem_bus.write_enable &&
                      (mem_bus.address_to_mem == HALT_ADDR);
   assign limit_hit = in_run && (cycle_count == LIMIT_M1);
   // The halting store is traced like any other store (if inside the window)
   assign capture   = in_run && mem_bus.write_enable && in_window;
   assign full      = (trace_count == FULL_CNT);
   assign state_dbg = state;

   // Run-control FSM plus trace bookkeeping; status outputs are set on the
   // same edge as the state change so they track the state register exactly
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         wr_ptr      <= '0;
         trace_count <= '0;
         cycle_count <= '0;
         overflow    <= 1'b0;
         halt_data   <= '0;
         done        <= 1'b0;
         pass        <= 1'b0;
         timed_out   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: state <= S_RUN;
            S_RUN: begin
               cycle_count <= cycle_count + CNT_W'(1);
               // Halt has priority over the cycle limit on the same edge
               if (halt_hit) begin
                  state     <= S_HALTED;
                  done      <= 1'b1;
                  pass      <= (mem_bus.data_to_mem == PASS_VALUE);
                  halt_data <= mem_bus.data_to_mem;
               end else if (limit_hit) begin
                  state     <= S_TIMEOUT;
                  done      <= 1'b1;
                  timed_out <= 1'b1;
               end
            end
            default: ; // HALTED and TIMEOUT are terminal until reset
         endcase
         if (capture) begin
            wr_ptr <= wr_ptr + IDX_W'(1);
            if (full) overflow <= 1'b1;
            else      trace_count <= trace_count + (IDX_W + 1)'(1);
         end
      end
   end

   // Trace storage; contents need no reset because trace_count gates reads
   always_ff @(posedge clk) begin
      if (capture) begin
         buf_addr[wr_ptr] <= mem_bus.address_to_mem;
         buf_data[wr_ptr] <= mem_bus.data_to_mem;
      end
   end

   // Combinational read port indexed from the oldest surviving entry
   always_comb begin
      oldest   = full ? wr_ptr : '0;
      phys_idx = oldest + rd_idx;
      rd_valid = ({1'b0, rd_idx} < trace_count);
      rd_addr  = rd_valid ? buf_addr[phys_idx] : '0;
      rd_data  = rd_valid ? buf_data[phys_idx] : '0;
   end

endmodule

// File: tb/tb_mem_write_tracer.sv
// Bench for mem_write_tracer: directed stores, expected values queued by the
// stimulus and compared by a negedge monitor.
module tb_mem_write_tracer;

   localparam int SEL_RD_ADDR  = 0;
   localparam int SEL_RD_DATA  = 1;
   localparam int SEL_RD_VALID = 2;
   localparam int SEL_TCOUNT   = 3;
   localparam int SEL_OVF      = 4;
   localparam int SEL_CYCLES   = 5;
   localparam int SEL_DONE     = 6;
   localparam int SEL_PASS     = 7;
   localparam int SEL_TIMEOUT  = 8;
   localparam int SEL_HDATA    = 9;
   localparam int SEL_STATE    = 10;

   logic        clk;
   logic        reset;
   logic [3:0]  rd_idx;
   logic [31:0] rd_addr;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic [4:0]  trace_count;
   logic        overflow;
   logic [15:0] cycle_count;
   logic        done;
   logic        pass;
   logic        timed_out;
   logic [31:0] halt_data;
   logic [1:0]  state_dbg;
`ifdef TRACE_FILTER_EN
   logic [31:0] filt_lo;
   logic [31:0] filt_hi;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   int          sel_q[$];
   string       name_q[$];

   mem_write_tracer_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

   mem_write_tracer dut (
      .clk         (clk),
      .reset       (reset),
      .mem_bus     (mem_bus),
      .rd_idx      (rd_idx),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .trace_count (trace_count),
      .overflow    (overflow),
      .cycle_count (cycle_count),
      .done        (done),
      .pass        (pass),
      .timed_out   (timed_out),
      .halt_data   (halt_data),
`ifdef TRACE_FILTER_EN
      .filt_lo     (filt_lo),
      .filt_hi     (filt_hi),
`endif
      .state_dbg   (state_dbg)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] actual_of(input int sel);
      case (sel)
         SEL_RD_ADDR:  return rd_addr;
         SEL_RD_DATA:  return rd_data;
         SEL_RD_VALID: return {31'd0, rd_valid};
         SEL_TCOUNT:   return {27'd0, trace_count};
         SEL_OVF:      return {31'd0, overflow};
         SEL_CYCLES:   return {16'd0, cycle_count};
         SEL_DONE:     return {31'd0, done};
         SEL_PASS:     return {31'd0, pass};
         SEL_TIMEOUT:  return {31'd0, timed_out};
         SEL_HDATA:    return halt_data;
         SEL_STATE:    return {30'd0, state_dbg};
         default:      return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Scoreboard monitor: drains every queued expectation against live outputs
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         logic [31:0] e;
         logic [31:0] a;
         int          s;
         string       n;
         e = exp_q.pop_front();
         s = sel_q.pop_front();
         n = name_q.pop_front();
         a = actual_of(s);
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
         end
      end
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic expect_val(input int sel, input logic [31:0] e, input string n);
      exp_q.push_back(e);
      sel_q.push_back(sel);
      name_q.push_back(n);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      mem_bus.write_enable   = 1'b1;
      mem_bus.address_to_mem = a;
      mem_bus.data_to_mem    = d;
      tick();
      mem_bus.write_enable   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic read_entry(input logic [3:0] idx, input logic [31:0] ea,
                             input logic [31:0] ed, input string n);
      rd_idx = idx;
      expect_val(SEL_RD_VALID, 32'd1, {n, "_valid"});
      expect_val(SEL_RD_ADDR, ea, {n, "_addr"});
      expect_val(SEL_RD_DATA, ed, {n, "_data"});
      settle();
   endtask

   // Stimulus
   initial begin
      reset                  = 1'b1;
      rd_idx                 = '0;
      mem_bus.write_enable   = 1'b0;
      mem_bus.address_to_mem = '0;
      mem_bus.data_to_mem    = '0;
`ifdef TRACE_FILTER_EN
      filt_lo = 32'h20;
      filt_hi = 32'h2F;
`endif
      tick();

      // Reset state
      expect_val(SEL_STATE,   32'd0, "rst_state");
      expect_val(SEL_TCOUNT,  32'd0, "rst_tcount");
      expect_val(SEL_CYCLES,  32'd0, "rst_cycles");
      expect_val(SEL_OVF,     32'd0, "rst_ovf");
      expect_val(SEL_DONE,    32'd0, "rst_done");
      expect_val(SEL_PASS,    32'd0, "rst_pass");
      expect_val(SEL_TIMEOUT, 32'd0, "rst_timeout");
      expect_val(SEL_HDATA,   32'd0, "rst_hdata");
      expect_val(SEL_RD_VALID, 32'd0, "rst_rd_valid");
      settle();

      // 1: two stores traced in order; store during IDLE ignored
      reset = 1'b0;
      store(32'h80, 32'h99);            // this edge is IDLE->RUN
      store(32'h10, 32'hA);
      store(32'h14, 32'hB);
      expect_val(SEL_TCOUNT, 32'd2, "t1_tcount");
      expect_val(SEL_DONE,   32'd0, "t1_done");
      expect_val(SEL_STATE,  32'd1, "t1_state");
      read_entry(4'd0, 32'h10, 32'hA, "t1_rd0");
      read_entry(4'd1, 32'h14, 32'hB, "t1_rd1");
      rd_idx = 4'd2;
      expect_val(SEL_RD_VALID, 32'd0, "t1_rd2_valid");
      expect_val(SEL_RD_ADDR,  32'd0, "t1_rd2_addr");
      expect_val(SEL_RD_DATA,  32'd0, "t1_rd2_data");
      settle();

      // 2: pass halt at RUN cycle 5
      do_reset();
      tick();                           // IDLE->RUN, cycle_count=0
      repeat (5) tick();                // cycle_count=5
      store(32'hFC, 32'h1);
      expect_val(SEL_DONE,    32'd1, "t2_done");
      expect_val(SEL_PASS,    32'd1, "t2_pass");
      expect_val(SEL_TIMEOUT, 32'd0, "t2_timeout");
      expect_val(SEL_HDATA,   32'd1, "t2_hdata");
      expect_val(SEL_CYCLES,  32'd6, "t2_cycles");
      expect_val(SEL_STATE,   32'd2, "t2_state");
      expect_val(SEL_TCOUNT,  32'd1, "t2_tcount");
      settle();
      read_entry(4'd0, 32'hFC, 32'h1, "t2_rd0");
      store(32'h40, 32'h5);
      store(32'h44, 32'h6);
      repeat (3) tick();
      expect_val(SEL_TCOUNT, 32'd1, "t2_tcount_after");
      expect_val(SEL_CYCLES, 32'd6, "t2_cycles_frozen");
      settle();

      // 3: timeout after 250 RUN edges
      do_reset();
      tick();
      repeat (249) tick();
      expect_val(SEL_DONE,   32'd0,   "t3_done_early");
      expect_val(SEL_CYCLES, 32'd249, "t3_cycles_early");
      settle();
      tick();
      expect_val(SEL_TIMEOUT, 32'd1,   "t3_timeout");
      expect_val(SEL_DONE,    32'd1,   "t3_done");
      expect_val(SEL_PASS,    32'd0,   "t3_pass");
      expect_val(SEL_CYCLES,  32'd250, "t3_cycles");
      expect_val(SEL_STATE,   32'd3,   "t3_state");
      settle();
      store(32'hFC, 32'h1);
      repeat (2) tick();
      expect_val(SEL_CYCLES, 32'd250, "t3_cycles_frozen");
      expect_val(SEL_PASS,   32'd0,   "t3_pass_after");
      expect_val(SEL_TCOUNT, 32'd0,   "t3_tcount");
      settle();

      // 4: overflow after 18 stores into 16 entries
      do_reset();
      tick();
      for (int i = 1; i <= 16; i++) store(32'h100 + 32'(4 * (i - 1)), 32'(i));
      expect_val(SEL_TCOUNT, 32'd16, "t4_tcount_full");
      expect_val(SEL_OVF,    32'd0,  "t4_ovf_full");
      settle();
      read_entry(4'd0,  32'h100, 32'd1,  "t4_full_rd0");
      tick();
      for (int i = 17; i <= 18; i++) store(32'h100 + 32'(4 * (i - 1)), 32'(i));
      expect_val(SEL_TCOUNT, 32'd16, "t4_tcount");
      expect_val(SEL_OVF,    32'd1,  "t4_ovf");
      settle();
      read_entry(4'd0,  32'h108, 32'd3,  "t4_rd0");
      read_entry(4'd1,  32'h10C, 32'd4,  "t4_rd1");
      read_entry(4'd14, 32'h140, 32'd17, "t4_rd14");
      read_entry(4'd15, 32'h144, 32'd18, "t4_rd15");

      // 5: halt on the limit cycle with a failing value
      do_reset();
      tick();
      repeat (249) tick();
      store(32'hFC, 32'h7);
      expect_val(SEL_STATE,   32'd2,   "t5_state");
      expect_val(SEL_TIMEOUT, 32'd0,   "t5_timeout");
      expect_val(SEL_DONE,    32'd1,   "t5_done");
      expect_val(SEL_PASS,    32'd0,   "t5_pass");
      expect_val(SEL_HDATA,   32'd7,   "t5_hdata");
      expect_val(SEL_CYCLES,  32'd250, "t5_cycles");
      settle();

      // 6: asynchronous reset mid-run, restart, address filter
      do_reset();
      tick();
      store(32'h24, 32'h11);
      store(32'h28, 32'h12);
      repeat (38) tick();
      expect_val(SEL_CYCLES, 32'd40, "t6_cycles_pre");
      settle();
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      expect_val(SEL_CYCLES, 32'd0, "t6_async_cycles");
      expect_val(SEL_TCOUNT, 32'd0, "t6_async_tcount");
      expect_val(SEL_STATE,  32'd0, "t6_async_state");
      expect_val(SEL_DONE,   32'd0, "t6_async_done");
      settle();
      reset = 1'b0;
      tick();                           // IDLE->RUN
      expect_val(SEL_STATE,  32'd1, "t6_restart_state");
      expect_val(SEL_CYCLES, 32'd0, "t6_restart_cycles");
      settle();
      store(32'h10, 32'h55);
      store(32'h24, 32'h66);
`ifdef TRACE_FILTER_EN
      expect_val(SEL_TCOUNT, 32'd1, "t6_filt_tcount");
      settle();
      read_entry(4'd0, 32'h24, 32'h66, "t6_filt_rd0");
      store(32'hFC, 32'h1);
      expect_val(SEL_PASS,   32'd1, "t6_filt_pass");
      expect_val(SEL_TCOUNT, 32'd1, "t6_filt_halt_tcount");
      settle();
`else
      expect_val(SEL_TCOUNT, 32'd2, "t6_nofilt_tcount");
      settle();
      read_entry(4'd0, 32'h10, 32'h55, "t6_nofilt_rd0");
      read_entry(4'd1, 32'h24, 32'h66, "t6_nofilt_rd1");
      store(32'hFC, 32'h1);
      expect_val(SEL_PASS,   32'd1, "t6_nofilt_pass");
      expect_val(SEL_TCOUNT, 32'd3, "t6_nofilt_halt_tcount");
      settle();
`endif

      // Final report
      repeat (2) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
